sync_fifo_wr_arbiter: RTL and testbench



---
 rtl/sync_fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_sync_fifo_wr_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port among N_REQ producers,
// with bounded-burst ownership and full-flag backpressure.
module sync_fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned SRC_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned CNT_W     = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            ack_o,
    input  logic                        fifo_full_i,
    output logic                        fifo_write_o,
    output logic [DATA_WIDTH-1:0]       fifo_wr_data_o,
    output logic [SRC_W-1:0]            fifo_wr_src_o,
    output logic                        busy_o
);

    localparam int unsigned PTR_W = SRC_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] owner;
    logic [CNT_W-1:0] burst_cnt;

    logic             found;
    logic [SRC_W-1:0] winner;
    logic [PTR_W-1:0] scan;
    logic             grant;
    logic [SRC_W-1:0] sel;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [SRC_W-1:0] ptr_inc(input logic [SRC_W-1:0] p);
        return (p == SRC_W'(N_REQ - 1)) ? '0 : p + SRC_W'(1);
    endfunction

    // First requester at or after rr_ptr, wrapping at N_REQ (not a power of 2 in general).
    always_comb begin
        found  = 1'b0;
        winner = '0;
        scan   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            scan = {1'b0, rr_ptr} + PTR_W'(i);
            if (scan >= PTR_W'(N_REQ)) begin
                scan = scan - PTR_W'(N_REQ);
            end
            if (!found && req_i[SRC_W'(scan)]) begin
                found  = 1'b1;
                winner = SRC_W'(scan);
            end
        end
    end

    // Grant decision; everything is forced quiet while reset is asserted.
    always_comb begin
        grant = 1'b0;
        sel   = '0;
        if (state == IDLE) begin
            if (found && !fifo_full_i) begin
                grant = 1'b1;
                sel   = winner;
            end
        end else begin
            if (req_i[owner] && !fifo_full_i) begin
                grant = 1'b1;
                sel   = owner;
            end
        end
        if (rst_i) begin
            grant = 1'b0;
            sel   = '0;
        end
    end

    assign cnt_inc = burst_cnt + CNT_W'(1);

    // Zero-latency write-side datapath.
    always_comb begin
        ack_o          = '0;
        fifo_wr_data_o = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (grant && (sel == SRC_W'(k))) begin
                ack_o[k]       = 1'b1;
                fifo_wr_data_o = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        fifo_write_o  = grant;
        fifo_wr_src_o = sel;
        busy_o        = (state == BURST) && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= sel;
                        burst_cnt <= CNT_W'(1);
                        if (MAX_BURST == 1) begin
                            rr_ptr <= ptr_inc(sel);
                        end else begin
                            state <= BURST;
                        end
                    end
                end
                BURST: begin
                    // A dropped request releases ownership with a one-cycle bubble.
                    if (!req_i[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= ptr_inc(owner);
                    end else if (grant) begin
                        burst_cnt <= cnt_inc;
                        if (cnt_inc == CNT_W'(MAX_BURST)) begin
                            state  <= IDLE;
                            rr_ptr <= ptr_inc(owner);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Scoreboard bench: directed stimulus queues per-cycle expectations, a negedge monitor
// pops and compares them for a 4-requester/burst-4 and a 3-requester/burst-1 instance.
module tb_sync_fifo_wr_arbiter;

    typedef struct {
        logic [3:0]  ack;
        logic        wr;
        logic [1:0]  src;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Four requesters, bursts of four
    logic         rst4, full4, wr4, busy4;
    logic [3:0]   req4, ack4;
    logic [127:0] data4;
    logic [31:0]  wdata4;
    logic [1:0]   src4;

    // Three requesters, pure per-word round-robin
    logic         rst3, full3, wr3, busy3;
    logic [2:0]   req3, ack3;
    logic [95:0]  data3;
    logic [31:0]  wdata3;
    logic [1:0]   src3;

    exp_t q4[$];
    exp_t q3[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    sync_fifo_wr_arbiter #(.DATA_WIDTH(32), .N_REQ(4), .MAX_BURST(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst4), .req_i(req4), .req_data_i(data4), .ack_o(ack4),
        .fifo_full_i(full4), .fifo_write_o(wr4), .fifo_wr_data_o(wdata4),
        .fifo_wr_src_o(src4), .busy_o(busy4)
    );

    sync_fifo_wr_arbiter #(.DATA_WIDTH(32), .N_REQ(3), .MAX_BURST(1)) u_dut3 (
        .clk_i(clk), .rst_i(rst3), .req_i(req3), .req_data_i(data3), .ack_o(ack3),
        .fifo_full_i(full3), .fifo_write_o(wr3), .fifo_wr_data_o(wdata3),
        .fifo_wr_src_o(src3), .busy_o(busy3)
    );

    function automatic logic [31:0] dat4(input logic [1:0] k);
        return 32'hA000_0000 + 32'(k) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] dat3(input logic [1:0] k);
        return 32'hB000_0000 + 32'(k) * 32'h0000_1111;
    endfunction

    task automatic step4(input logic r, input logic [3:0] rq, input logic f,
                         input logic w, input logic [1:0] s, input logic b);
        exp_t e;
        rst4 = r; req4 = rq; full4 = f;
        e.wr   = w;
        e.src  = w ? s : 2'd0;
        e.ack  = w ? (4'b0001 << s) : 4'b0000;
        e.data = w ? dat4(s) : 32'd0;
        e.busy = b;
        q4.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic step3(input logic r, input logic [2:0] rq, input logic f,
                         input logic w, input logic [1:0] s, input logic b);
        exp_t e;
        rst3 = r; req3 = rq; full3 = f;
        e.wr   = w;
        e.src  = w ? s : 2'd0;
        e.ack  = w ? (4'b0001 << s) : 4'b0000;
        e.data = w ? dat3(s) : 32'd0;
        e.busy = b;
        q3.push_back(e);
        @(posedge clk); #1;
    endtask

    function automatic void check(input string name, input exp_t e, input logic [3:0] ack,
                                  input logic wr, input logic [1:0] src, input logic [31:0] data,
                                  input logic busy);
        n_cmp++;
        if ({ack, wr, src, data, busy} !== {e.ack, e.wr, e.src, e.data, e.busy}) begin
            n_fail++;
            $display("FAIL %s @%0t: got ack=%b wr=%b src=%0d data=%h busy=%b, want ack=%b wr=%b src=%0d data=%h busy=%b",
                     name, $time, ack, wr, src, data, busy, e.ack, e.wr, e.src, e.data, e.busy);
        end
    endfunction

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            check("dut4", e, ack4, wr4, src4, wdata4, busy4);
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            check("dut3", e, {1'b0, ack3}, wr3, src3, wdata3, busy3);
        end
    end

    initial begin
        rst4 = 1'b1; req4 = '0; full4 = 1'b0;
        rst3 = 1'b1; req3 = '0; full3 = 1'b0;
        for (int k = 0; k < 4; k++) data4[k*32 +: 32] = dat4(2'(k));
        for (int k = 0; k < 3; k++) data3[k*32 +: 32] = dat3(2'(k));
        @(posedge clk); #1;

        // Reset with everyone requesting: silent outputs
        step4(1, 4'hF, 0, 0, 0, 0);
        step4(1, 4'hF, 0, 0, 0, 0);
        // Continuous requests: 4-word bursts rotating 0,1,2,3,0
        for (int blk = 0; blk < 4; blk++)
            for (int w = 0; w < 4; w++)
                step4(0, 4'hF, 0, 1, 2'(blk), w != 0);
        step4(0, 4'hF, 0, 1, 0, 0);
        step4(0, 4'hF, 0, 1, 0, 1);
        // Full stalls owner 0 mid-burst, then it finishes and rotation goes to 1
        for (int i = 0; i < 3; i++) step4(0, 4'hF, 1, 0, 0, 1);
        step4(0, 4'hF, 0, 1, 0, 1);
        step4(0, 4'hF, 0, 1, 0, 1);
        step4(0, 4'hF, 0, 1, 1, 0);
        step4(0, 4'hF, 0, 1, 1, 1);
        // Reset mid-burst (owner 1, two words in), then restart at requester 0
        step4(1, 4'hF, 0, 0, 0, 0);
        step4(0, 4'hF, 0, 1, 0, 0);
        // Owner 0 drops: bubble, rr_ptr -> 1
        step4(0, 4'b0000, 0, 0, 0, 1);
        // Only requester 2 for two words, then drops: rr_ptr -> 3
        step4(0, 4'b0100, 0, 1, 2, 0);
        step4(0, 4'b0100, 0, 1, 2, 1);
        step4(0, 4'b0000, 0, 0, 0, 1);
        // 0 and 3 requesting: 3 wins; 0 ignored while 3 owns
        step4(0, 4'b1001, 0, 1, 3, 0);
        step4(0, 4'b1001, 0, 1, 3, 1);
        step4(0, 4'b0001, 0, 0, 0, 1);
        // Full in IDLE, then no requests, then 0 granted
        step4(0, 4'b0001, 1, 0, 0, 0);
        step4(0, 4'b0000, 0, 0, 0, 0);
        step4(0, 4'b0001, 0, 1, 0, 0);
        rst4 = 1'b1;

        // Per-word round-robin over three requesters
        step3(1, 3'b111, 0, 0, 0, 0);
        step3(0, 3'b111, 0, 1, 0, 0);
        step3(0, 3'b111, 0, 1, 1, 0);
        step3(0, 3'b111, 0, 1, 2, 0);
        step3(0, 3'b111, 0, 1, 0, 0);
        step3(0, 3'b111, 0, 1, 1, 0);
        step3(0, 3'b111, 1, 0, 0, 0);
        step3(0, 3'b111, 0, 1, 2, 0);
        step3(0, 3'b001, 0, 1, 0, 0);
        step3(0, 3'b011, 0, 1, 1, 0);
        rst3 = 1'b1;

        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (q4.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q4.size(), q3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
